pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline control unit for the Y86-64 5-stage core. Combinationally issues stall/bubble
//  controls for the F/D/E/M/W registers (load-use, ret, mispredict, exception) and owns
//  a registered run-state FSM: post-reset flush, run, halted, error. Sits beside the
//  decode-stage forwarding muxes; needs stage icodes, register IDs, e_Cnd and stats.
// PARAMETERS
//  INIT_CYC  2   cycles of forced flush after reset release (>=1)
//  CNT_W     32  perf-counter width
// PORTS
//  clk         in   1  core clock
//  rst         in   1  asynchronous reset, active high
//  D_icode     in   4  icode in D register
//  d_srcA      in   4  decode srcA (4'hF = none)
//  d_srcB      in   4  decode srcB
//  E_icode     in   4  icode in E register
//  E_dstM      in   4  E-stage dstM
//  e_Cnd       in   1  branch condition from execute
//  M_icode     in   4  icode in M register
//  m_stat      in   3  memory-stage status
//  W_stat      in   3  writeback-stage status
//  W_icode     in   4  icode in W register
//  F_stall     out  1  hold F (PC) register
//  D_stall     out  1  hold D register
//  D_bubble    out  1  load nop into D
//  E_bubble    out  1  load nop into E
//  M_bubble    out  1  load nop into M
//  W_stall     out  1  hold W register
//  cpu_stat    out  3  registered architectural status
//  halted      out  1  registered, 1 in HALT or ERR
//  perf_cyc/perf_ret/perf_lu/perf_mis  out CNT_W  counters (PERF_CNT_EN only)
// BEHAVIOUR
//  - Encodings: icodes HALT=0 NOP=1 JXX=7 CALL=8 RET=9 MRMOV=5 POP=B; stat AOK=1 HLT=2 ADR=3 INS=4.
//  - load_use = (E_icode==MRMOV|POP) && E_dstM!=F && E_dstM in {d_srcA,d_srcB}.
//  - ret_in = RET in {D_icode,E_icode,M_icode}; mis = E_icode==JXX && !e_Cnd.
//  - exc_m = m_stat in {ADR,INS,HLT}; exc_w = W_stat in {ADR,INS,HLT}.
//  - FSM states INIT, RUN, HALT, ERR; reset -> INIT, init counter = INIT_CYC-1.
//  - INIT: F_stall=1, D_bubble=E_bubble=M_bubble=1, D_stall=W_stall=0; counter decrements,
//    at 0 -> RUN next cycle. Reset asserted mid-flush restarts the count.
//  - RUN (combinational, same cycle): F_stall=load_use|ret_in; D_stall=load_use;
//    D_bubble=mis|(!load_use&ret_in); E_bubble=mis|load_use; M_bubble=exc_m|exc_w; W_stall=exc_w.
//    Priority: load_use with ret_in -> D stalled, not bubbled (D_stall and D_bubble never both 1).
//  - RUN->HALT when W_stat==HLT; RUN->ERR when W_stat in {ADR,INS}; other stat values ignored.
//  - HALT/ERR sticky until rst: F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, D_bubble=0.
//  - cpu_stat: reset AOK; updates to W_stat on the RUN->HALT/ERR transition, then frozen.
//  - halted: reset 0; 1 from the cycle after the transition. All outputs 0 except as above
//    while rst high (combinational outputs follow INIT).
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined: four saturating CNT_W counters, reset 0, count only in RUN:
//    perf_cyc every cycle, perf_ret when W_stat==AOK && W_icode!=NOP, perf_lu on load_use,
//    perf_mis on mis. Undefined: perf_* ports absent, no counter flops.
// STRUCTURE
//  - y86_pkg: icode/stat localparams, REG_NONE=4'hF, run-state enum.
//  - Sub-module pipe_perf_cnt (four counters + saturation), instantiated only under macro.
//  - Top: hazard decode (comb) + FSM/init counter (seq).
// TESTING
//  1 rst pulse, INIT_CYC=2 -> 2 cycles F_stall=1 & bubbles=1, then RUN with all controls 0.
//  2 E_icode=5,E_dstM=3,d_srcA=3 -> F_stall=D_stall=E_bubble=1, D_bubble=0, one cycle only.
//  3 E_icode=7,e_Cnd=0 -> D_bubble=E_bubble=1, F_stall=0; perf_mis +1.
//  4 D_icode=9 then E, M -> F_stall=1,D_bubble=1 for 3 cycles; with load_use concurrently D_bubble=0.
//  5 m_stat=3 -> M_bubble=1; next W_stat=3 -> W_stall=1, then cpu_stat=3, halted=1, held 10 cycles.
//  6 W_stat=2 in RUN -> HALT sticky; rst mid-HALT -> INIT, cpu_stat=1, halted=0, counters 0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the run-state type for the pipeline control unit.
package y86_pkg;

    localparam logic [3:0] ICODE_HALT  = 4'h0;
    localparam logic [3:0] ICODE_NOP   = 4'h1;
    localparam logic [3:0] ICODE_MRMOV = 4'h5;
    localparam logic [3:0] ICODE_JXX   = 4'h7;
    localparam logic [3:0] ICODE_CALL  = 4'h8;
    localparam logic [3:0] ICODE_RET   = 4'h9;
    localparam logic [3:0] ICODE_POP   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [1:0] {
        StInit,
        StRun,
        StHalt,
        StErr
    } run_state_t;

    function automatic logic is_exc(input logic [2:0] stat);
        return (stat == STAT_ADR) || (stat == STAT_INS) || (stat == STAT_HLT);
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Four saturating performance counters that advance only while the core is running.
module pipe_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_run,
    input  logic             i_ret,
    input  logic             i_lu,
    input  logic             i_mis,
    output logic [CNT_W-1:0] o_cyc,
    output logic [CNT_W-1:0] o_ret,
    output logic [CNT_W-1:0] o_lu,
    output logic [CNT_W-1:0] o_mis
);

    logic [3:0][CNT_W-1:0] r_cnt;
    logic [3:0]            w_inc;

    assign w_inc = {i_mis, i_lu, i_ret, 1'b1} & {4{i_run}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                // Saturate at all-ones rather than wrapping.
                if (w_inc[i] && (r_cnt[i] != '1)) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign o_cyc = r_cnt[0];
    assign o_ret = r_cnt[1];
    assign o_lu  = r_cnt[2];
    assign o_mis = r_cnt[3];

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: combinational stall/bubble decode plus a registered run-state FSM.
// Optional perf counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int unsigned INIT_CYC = 2,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    input  logic [3:0]       W_icode,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic [2:0]       cpu_stat,
    output logic             halted
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_cyc,
    output logic [CNT_W-1:0] perf_ret,
    output logic [CNT_W-1:0] perf_lu,
    output logic [CNT_W-1:0] perf_mis
`endif
);

    localparam int unsigned   CW        = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
    localparam logic [CW-1:0] INIT_LOAD = CW'(INIT_CYC - 1);

    run_state_t    r_state;
    logic [CW-1:0] r_init_cnt;
    logic [2:0]    r_cpu_stat;
    logic          r_halted;

    logic w_load_use;
    logic w_ret_in;
    logic w_mis;
    logic w_exc_m;
    logic w_exc_w;

    assign w_load_use = ((E_icode == ICODE_MRMOV) || (E_icode == ICODE_POP)) &&
                        (E_dstM != REG_NONE) &&
                        ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign w_ret_in   = (D_icode == ICODE_RET) || (E_icode == ICODE_RET) ||
                        (M_icode == ICODE_RET);
    assign w_mis      = (E_icode == ICODE_JXX) && !e_Cnd;
    assign w_exc_m    = is_exc(m_stat);
    assign w_exc_w    = is_exc(W_stat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StInit;
            r_init_cnt <= INIT_LOAD;
            r_cpu_stat <= STAT_AOK;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                StInit: begin
                    if (r_init_cnt == '0) begin
                        r_state <= StRun;
                    end else begin
                        r_init_cnt <= r_init_cnt - CW'(1);
                    end
                end
                StRun: begin
                    if (W_stat == STAT_HLT) begin
                        r_state    <= StHalt;
                        r_cpu_stat <= W_stat;
                        r_halted   <= 1'b1;
                    end else if ((W_stat == STAT_ADR) || (W_stat == STAT_INS)) begin
                        r_state    <= StErr;
                        r_cpu_stat <= W_stat;
                        r_halted   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        case (r_state)
            StInit: begin
                F_stall  = 1'b1;
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
            end
            StRun: begin
                F_stall  = w_load_use | w_ret_in;
                D_stall  = w_load_use;
                // A load-use stall wins over the ret bubble so D is never both held and flushed.
                D_bubble = w_mis | (!w_load_use & w_ret_in);
                E_bubble = w_mis | w_load_use;
                M_bubble = w_exc_m | w_exc_w;
                W_stall  = w_exc_w;
            end
            default: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                W_stall  = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
            end
        endcase
    end

    assign cpu_stat = r_cpu_stat;
    assign halted   = r_halted;

`ifdef PIPE_PERF_CNT_EN
    logic w_ret_ok;
    assign w_ret_ok = (W_stat == STAT_AOK) && (W_icode != ICODE_NOP);

    pipe_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk   (clk),
        .rst   (rst),
        .i_run (r_state == StRun),
        .i_ret (w_ret_ok),
        .i_lu  (w_load_use),
        .i_mis (w_mis),
        .o_cyc (perf_cyc),
        .o_ret (perf_ret),
        .o_lu  (perf_lu),
        .o_mis (perf_mis)
    );
`else
    logic w_unused_w_icode;
    assign w_unused_w_icode = ^W_icode;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: fixed vector table, directed multi-cycle sequences and
// randomized stimulus against a behavioural model (perf counters checked if PIPE_PERF_CNT_EN).
module tb_pipe_ctrl;

    localparam int unsigned INIT_CYC = 2;
    localparam int unsigned CNT_W    = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
    logic       e_Cnd;
    logic [2:0] m_stat, W_stat;
    logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
    logic [2:0] cpu_stat;
    logic       halted;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] perf_cyc, perf_ret, perf_lu, perf_mis;
`endif

    int n_vec = 0;
    int n_err = 0;

    pipe_ctrl #(
        .INIT_CYC (INIT_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .D_icode  (D_icode),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .E_icode  (E_icode),
        .E_dstM   (E_dstM),
        .e_Cnd    (e_Cnd),
        .M_icode  (M_icode),
        .m_stat   (m_stat),
        .W_stat   (W_stat),
        .W_icode  (W_icode),
        .F_stall  (F_stall),
        .D_stall  (D_stall),
        .D_bubble (D_bubble),
        .E_bubble (E_bubble),
        .M_bubble (M_bubble),
        .W_stall  (W_stall),
        .cpu_stat (cpu_stat),
        .halted   (halted)
`ifdef PIPE_PERF_CNT_EN
        ,
        .perf_cyc (perf_cyc),
        .perf_ret (perf_ret),
        .perf_lu  (perf_lu),
        .perf_mis (perf_mis)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: mode 0=flushing, 1=running, 2=halted, 3=error.
    int          m_mode;
    int          m_flush_done;
    logic [2:0]  m_cpu_stat;
    logic        m_halted;
    longint      m_cyc, m_ret, m_lu, m_mis;

    function automatic bit f_lu();
        return (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
               (E_dstM == d_srcA || E_dstM == d_srcB);
    endfunction

    function automatic bit f_mis();
        return E_icode == 4'h7 && !e_Cnd;
    endfunction

    function automatic bit f_bad(input logic [2:0] s);
        return s == 3'd2 || s == 3'd3 || s == 3'd4;
    endfunction

    // Expected {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}.
    function automatic logic [5:0] model_ctrl();
        bit lu, ret_in, mis;
        lu     = f_lu();
        mis    = f_mis();
        ret_in = D_icode == 4'h9 || E_icode == 4'h9 || M_icode == 4'h9;
        if (m_mode == 0) return 6'b101110;
        if (m_mode >= 2) return 6'b110111;
        return {lu | ret_in, lu, mis | (!lu & ret_in), mis | lu,
                f_bad(m_stat) | f_bad(W_stat), f_bad(W_stat)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_flush_done = 0; m_cpu_stat = 3'd1; m_halted = 1'b0;
        m_cyc = 0; m_ret = 0; m_lu = 0; m_mis = 0;
    endtask

    task automatic model_update();
        if (rst) begin
            model_reset();
        end else if (m_mode == 0) begin
            m_flush_done++;
            if (m_flush_done == INIT_CYC) m_mode = 1;
        end else if (m_mode == 1) begin
            m_cyc++;
            if (W_stat == 3'd1 && W_icode != 4'h1) m_ret++;
            if (f_lu()) m_lu++;
            if (f_mis()) m_mis++;
            if (W_stat == 3'd2) begin
                m_mode = 2; m_cpu_stat = W_stat; m_halted = 1'b1;
            end else if (W_stat == 3'd3 || W_stat == 3'd4) begin
                m_mode = 3; m_cpu_stat = W_stat; m_halted = 1'b1;
            end
        end
    endtask

    task automatic check(input string name);
        logic [5:0] act, exp;
        act = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};
        exp = model_ctrl();
        n_vec++;
        if (act !== exp || cpu_stat !== m_cpu_stat || halted !== m_halted) begin
            n_err++;
            $display("FAIL %s: got ctrl=%b stat=%0d halted=%b, want ctrl=%b stat=%0d halted=%b",
                     name, act, cpu_stat, halted, exp, m_cpu_stat, m_halted);
        end
`ifdef PIPE_PERF_CNT_EN
        n_vec++;
        if (perf_cyc !== CNT_W'(m_cyc) || perf_ret !== CNT_W'(m_ret) ||
            perf_lu !== CNT_W'(m_lu) || perf_mis !== CNT_W'(m_mis)) begin
            n_err++;
            $display("FAIL %s_perf: got %0d/%0d/%0d/%0d, want %0d/%0d/%0d/%0d", name, perf_cyc,
                     perf_ret, perf_lu, perf_mis, m_cyc, m_ret, m_lu, m_mis);
        end
`endif
    endtask

    // Check at the falling edge, advance the model on the rising edge, return just after it.
    task automatic cycle(input string name);
        @(negedge clk);
        check(name);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_idle();
        D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF; E_icode = 4'h1; E_dstM = 4'hF;
        e_Cnd = 1'b1; M_icode = 4'h1; m_stat = 3'd1; W_stat = 3'd1; W_icode = 4'h1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        set_idle();
        cycle("rst_held");
        rst = 1'b0;
        for (int i = 0; i < INIT_CYC; i++) cycle("flush");
        cycle("run_idle");
    endtask

    typedef struct {
        string      name;
        logic [3:0] di, sa, sb, ei, ed;
        logic       cnd;
        logic [3:0] mi;
        logic [2:0] ms, ws;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        tbl.push_back('{"idle",       4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1, 6'b000000});
        tbl.push_back('{"lu_srcA",    4'h6, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, 3'd1, 3'd1, 6'b110100});
        tbl.push_back('{"lu_pop_B",   4'h6, 4'h2, 4'h4, 4'hB, 4'h4, 1'b1, 4'h1, 3'd1, 3'd1, 6'b110100});
        tbl.push_back('{"lu_none",    4'h6, 4'hF, 4'hF, 4'h5, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1, 6'b000000});
        tbl.push_back('{"lu_miss",    4'h6, 4'h2, 4'h4, 4'h5, 4'h3, 1'b1, 4'h1, 3'd1, 3'd1, 6'b000000});
        tbl.push_back('{"nonload",    4'h6, 4'h3, 4'hF, 4'h2, 4'h3, 1'b1, 4'h1, 3'd1, 3'd1, 6'b000000});
        tbl.push_back('{"mispred",    4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 3'd1, 3'd1, 6'b001100});
        tbl.push_back('{"jmp_taken",  4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1, 6'b000000});
        tbl.push_back('{"ret_D",      4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1, 6'b101000});
        tbl.push_back('{"ret_E",      4'h1, 4'hF, 4'hF, 4'h9, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1, 6'b101000});
        tbl.push_back('{"ret_M",      4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h9, 3'd1, 3'd1, 6'b101000});
        tbl.push_back('{"ret_lu",     4'h9, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, 3'd1, 3'd1, 6'b110100});
        tbl.push_back('{"mis_retM",   4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h9, 3'd1, 3'd1, 6'b101100});
        tbl.push_back('{"mstat_adr",  4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd3, 3'd1, 6'b000010});
        tbl.push_back('{"mstat_ins",  4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd4, 3'd1, 6'b000010});
        tbl.push_back('{"mstat_hlt",  4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd2, 3'd1, 6'b000010});
        tbl.push_back('{"mstat_0",    4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd0, 3'd1, 6'b000000});
        tbl.push_back('{"wstat_5",    4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd5, 6'b000000});
        tbl.push_back('{"wstat_0",    4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd0, 6'b000000});

        do_reset();

        // Fixed RUN-state vectors, one cycle each.
        foreach (tbl[i]) begin
            D_icode = tbl[i].di; d_srcA = tbl[i].sa; d_srcB = tbl[i].sb; E_icode = tbl[i].ei;
            E_dstM = tbl[i].ed; e_Cnd = tbl[i].cnd; M_icode = tbl[i].mi; m_stat = tbl[i].ms;
            W_stat = tbl[i].ws; W_icode = 4'h6;
            @(negedge clk);
            n_vec++;
            if ({F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall} !== tbl[i].exp) begin
                n_err++;
                $display("FAIL %s: got ctrl=%b want %b", tbl[i].name,
                         {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}, tbl[i].exp);
            end
            check(tbl[i].name);
            @(posedge clk);
            model_update();
            #1;
        end

        // ret walking D -> E -> M, then again with a concurrent load-use.
        set_idle(); D_icode = 4'h9; cycle("ret_walk_D");
        set_idle(); E_icode = 4'h9; cycle("ret_walk_E");
        set_idle(); M_icode = 4'h9; cycle("ret_walk_M");
        set_idle(); D_icode = 4'h9; E_icode = 4'hB; E_dstM = 4'h2; d_srcB = 4'h2;
        cycle("ret_with_lu");
        set_idle(); cycle("after_ret");

        // Memory error, then the same error in W, then sticky ERR.
        set_idle(); m_stat = 3'd3; cycle("m_adr");
        set_idle(); W_stat = 3'd3; cycle("w_adr");
        for (int i = 0; i < 10; i++) begin
            set_idle(); W_stat = (i % 2 == 0) ? 3'd2 : 3'd1; cycle("err_sticky");
        end
        n_vec++;
        if (cpu_stat !== 3'd3 || halted !== 1'b1) begin
            n_err++;
            $display("FAIL err_final: got stat=%0d halted=%b want 3 1", cpu_stat, halted);
        end

        // HALT entry, sticky, then reset in the middle of HALT.
        do_reset();
        set_idle(); W_stat = 3'd2; cycle("w_hlt");
        set_idle(); W_stat = 3'd3; cycle("halt_sticky");
        set_idle(); cycle("halt_sticky");
        rst = 1'b1; model_reset();
        #1;
        n_vec++;
        if (cpu_stat !== 3'd1 || halted !== 1'b0 || F_stall !== 1'b1 || D_stall !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_halt: got stat=%0d halted=%b F=%b D=%b want 1 0 1 0",
                     cpu_stat, halted, F_stall, D_stall);
        end
        cycle("rst_mid_halt");
        // Reset during flush must restart the count.
        rst = 1'b0; cycle("flush_a");
        rst = 1'b1; model_reset(); cycle("rst_mid_flush");
        rst = 1'b0;
        for (int i = 0; i < INIT_CYC + 2; i++) cycle("reflush");

        // Randomized stimulus against the model.
        begin
            int stuck;
            stuck = 0;
            for (int i = 0; i < 600; i++) begin
                logic [3:0] pick;
                D_icode = 4'($urandom_range(0, 11));
                E_icode = 4'($urandom_range(0, 11));
                M_icode = 4'($urandom_range(0, 11));
                W_icode = 4'($urandom_range(0, 11));
                pick = 4'($urandom_range(0, 4)); d_srcA = (pick == 4'd4) ? 4'hF : pick;
                pick = 4'($urandom_range(0, 4)); d_srcB = (pick == 4'd4) ? 4'hF : pick;
                pick = 4'($urandom_range(0, 4)); E_dstM = (pick == 4'd4) ? 4'hF : pick;
                e_Cnd  = 1'($urandom_range(0, 1));
                m_stat = ($urandom_range(0, 99) < 80) ? 3'd1 : 3'($urandom_range(0, 7));
                W_stat = ($urandom_range(0, 99) < 96) ? 3'd1 : 3'($urandom_range(0, 7));
                stuck  = (m_mode >= 2) ? stuck + 1 : 0;
                if (stuck > 8 || $urandom_range(0, 99) < 2) begin
                    rst = 1'b1; model_reset(); stuck = 0;
                end else begin
                    rst = 1'b0;
                end
                cycle("random");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
